// File: rtl/down_counter_pkg.sv
// Shared types for the loadable down-counter: controller state encoding and
// the default counter width.
package down_counter_pkg;

  localparam int CD_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    CD_IDLE,
    CD_RUN,
    CD_DONE
  } cd_state_t;

endpackage

// File: rtl/down_counter_ctrl.sv
// Loadable down-counter with start/busy/done handshake. A run of N enabled
// cycles ends in a one-cycle done pulse; abort cancels without a pulse.
module down_counter_ctrl
  import down_counter_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             is_last,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      CD_IDLE, CD_DONE: begin
        state_d = CD_IDLE;
        count_d = '0;
        // DONE accepts a back-to-back reload; abort there suppresses it.
        if (!(state_q == CD_DONE && abort) && start) begin
          if (load_val != '0) begin
            state_d = CD_RUN;
            count_d = load_val - ONE;
          end else begin
            state_d = CD_DONE;
          end
        end
      end
      CD_RUN: begin
        if (abort) begin
          state_d = CD_IDLE;
          count_d = '0;
        end else if (enable) begin
          if (count_q != '0) count_d = count_q - ONE;
          else               state_d = CD_DONE;
        end
      end
      default: begin
        state_d = CD_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    count   = count_q;
    busy    = (state_q == CD_RUN);
    done    = (state_q == CD_DONE);
    is_last = (state_q == CD_RUN) && (count_q == '0);
  end

endmodule
